acc_seq_ctrl: RTL

ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

---
 rtl/acc_seq_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - burst sequencer driving an external accumulator register
// Sums len operands into the downstream register, with optional saturation and a sticky overflow flag.
module acc_seq_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 4,
   parameter int SAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        len,
   input  logic                    in_valid,
   input  logic signed [N-1:0]     in_data,
   output logic                    in_ready,
   input  logic signed [N-1:0]     ac_q,
   output logic                    ac_en,
   output logic signed [N-1:0]     ac_d,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf
);

   typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;

   localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
   localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic signed [N:0]   sum;
   logic signed [N-1:0] adj;
   logic                add_ovf;
   logic                hs;

   assign sum     = {ac_q[N-1], ac_q} + {in_data[N-1], in_data};
   assign add_ovf = (ac_q[N-1] == in_data[N-1]) && (sum[N-1] != ac_q[N-1]);

   // Overflow direction follows the common operand sign.
   always_comb begin
      adj = sum[N-1:0];
      if (add_ovf && (SAT != 0))
         adj = ac_q[N-1] ? MINV : MAXV;
   end

   // Combinational so the register loads on the acceptance edge itself.
   assign hs       = (state == ACCUM) && in_valid;
   assign in_ready = (state == ACCUM);
   assign ac_en    = (state == CLEAR) || hs;
   assign ac_d     = hs ? adj : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count <= len;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               if (count == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  count <= count - 1'b1;
                  if (add_ovf)
                     ovf <= 1'b1;
                  if (count == CNT_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
